// File: rtl/matrix_loader.sv
// Assembles two 3x3 operand matrices from a byte stream and strobes Load; outputs update on the edge
// that accepts the final byte. Ain_ready is low in LOAD and SETTLE, so the source holds its data.
module matrix_loader #(
   parameter int DATA_W        = 8,
   parameter int LOAD_CYCLES   = 1,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] Ain,
   input  logic              Ain_valid,
   input  logic              Ain_last,
   input  logic              Clear,
   output logic              Ain_ready,
   output logic [DATA_W-1:0] A00, A01, A02, A10, A11, A12, A20, A21, A22,
   output logic [DATA_W-1:0] B00, B01, B02, B10, B11, B12, B20, B21, B22,
   output logic              Load,
   output logic              Busy,
   output logic [4:0]        Count,
   output logic              Frame_err
);

   localparam int MAXC = (LOAD_CYCLES > SETTLE_CYCLES) ? LOAD_CYCLES : SETTLE_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] LOAD_LAST   = CW'(LOAD_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

   typedef enum logic [1:0] {COLLECT, LOAD, SETTLE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cyc_q, cyc_d;
   logic [4:0]        count_q, count_d;
   logic              err_q, err_d;
   logic              stage_we, out_we, xfer;
   logic [DATA_W-1:0] stage_q [17];
   logic [DATA_W-1:0] out_q   [18];

   assign xfer = Ain_valid && (state_q == COLLECT);

   always_comb begin
      state_d  = state_q;
      cyc_d    = cyc_q;
      count_d  = count_q;
      err_d    = 1'b0;
      stage_we = 1'b0;
      out_we   = 1'b0;
      case (state_q)
         COLLECT: begin
            // Clear wins over a same-cycle transfer: the byte is dropped.
            if (Clear) begin
               count_d = 5'd0;
            end else if (xfer) begin
               if (count_q == 5'd17 && Ain_last) begin
                  out_we  = 1'b1;
                  count_d = 5'd0;
                  cyc_d   = '0;
                  state_d = LOAD;
               end else if (count_q == 5'd17 || Ain_last) begin
                  err_d   = 1'b1;
                  count_d = 5'd0;
               end else begin
                  stage_we = 1'b1;
                  count_d  = count_q + 5'd1;
               end
            end
         end
         LOAD: begin
            if (cyc_q == LOAD_LAST) begin
               cyc_d   = '0;
               state_d = (SETTLE_CYCLES == 0) ? COLLECT : SETTLE;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         SETTLE: begin
            if (cyc_q == SETTLE_LAST) begin
               cyc_d   = '0;
               state_d = COLLECT;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= COLLECT;
         cyc_q   <= '0;
         count_q <= 5'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // The final byte bypasses staging and lands directly in B22.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 17; i++) stage_q[i] <= '0;
         for (int i = 0; i < 18; i++) out_q[i] <= '0;
      end else begin
         if (stage_we) stage_q[count_q] <= Ain;
         if (out_we) begin
            for (int i = 0; i < 17; i++) out_q[i] <= stage_q[i];
            out_q[17] <= Ain;
         end
      end
   end

   assign Ain_ready = (state_q == COLLECT);
   assign Load      = (state_q == LOAD);
   assign Busy      = (state_q != COLLECT);
   assign Count     = count_q;
   assign Frame_err = err_q;

   assign A00 = out_q[0];  assign A01 = out_q[1];  assign A02 = out_q[2];
   assign A10 = out_q[3];  assign A11 = out_q[4];  assign A12 = out_q[5];
   assign A20 = out_q[6];  assign A21 = out_q[7];  assign A22 = out_q[8];
   assign B00 = out_q[9];  assign B01 = out_q[10]; assign B02 = out_q[11];
   assign B10 = out_q[12]; assign B11 = out_q[13]; assign B12 = out_q[14];
   assign B20 = out_q[15]; assign B21 = out_q[16]; assign B22 = out_q[17];

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: two instances (1/4 and 3/0 load/settle timing) share one input stream.
module tb_matrix_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ain = 8'h00;
   logic       valid = 1'b0, last = 1'b0, clear = 1'b0;

   logic       rdy1, load1, busy1, ferr1;
   logic       rdy2, load2, busy2, ferr2;
   logic [4:0] cnt1, cnt2;
   logic [7:0] o1 [18];
   logic [7:0] o2 [18];

   int n_cmp = 0, n_err = 0;
   logic [143:0] q1[$], q2[$];
   logic lp1 = 1'b0, lp2 = 1'b0;
   logic [143:0] f1, f2, f3, f5;

   always #5 clk = ~clk;

   matrix_loader #(.DATA_W(8), .LOAD_CYCLES(1), .SETTLE_CYCLES(4)) dut1 (
      .clk(clk), .Reset(rst_n), .Ain(ain), .Ain_valid(valid), .Ain_last(last), .Clear(clear),
      .Ain_ready(rdy1),
      .A00(o1[0]), .A01(o1[1]), .A02(o1[2]), .A10(o1[3]), .A11(o1[4]), .A12(o1[5]),
      .A20(o1[6]), .A21(o1[7]), .A22(o1[8]),
      .B00(o1[9]), .B01(o1[10]), .B02(o1[11]), .B10(o1[12]), .B11(o1[13]), .B12(o1[14]),
      .B20(o1[15]), .B21(o1[16]), .B22(o1[17]),
      .Load(load1), .Busy(busy1), .Count(cnt1), .Frame_err(ferr1));

   matrix_loader #(.DATA_W(8), .LOAD_CYCLES(3), .SETTLE_CYCLES(0)) dut2 (
      .clk(clk), .Reset(rst_n), .Ain(ain), .Ain_valid(valid), .Ain_last(last), .Clear(clear),
      .Ain_ready(rdy2),
      .A00(o2[0]), .A01(o2[1]), .A02(o2[2]), .A10(o2[3]), .A11(o2[4]), .A12(o2[5]),
      .A20(o2[6]), .A21(o2[7]), .A22(o2[8]),
      .B00(o2[9]), .B01(o2[10]), .B02(o2[11]), .B10(o2[12]), .B11(o2[13]), .B12(o2[14]),
      .B20(o2[15]), .B21(o2[16]), .B22(o2[17]),
      .Load(load2), .Busy(busy2), .Count(cnt2), .Frame_err(ferr2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: each rising Load must match the oldest expected frame.
   always @(negedge clk) begin
      logic [143:0] g1, g2, e;
      for (int i = 0; i < 18; i++) begin
         g1[i*8 +: 8] = o1[i];
         g2[i*8 +: 8] = o2[i];
      end
      if (load1 && !lp1) begin
         n_cmp++;
         if (q1.size() == 0) begin
            n_err++;
            $display("FAIL dut1_load: got unexpected Load expected none");
         end else begin
            e = q1.pop_front();
            if (g1 !== e) begin
               n_err++;
               $display("FAIL dut1_frame: got %h expected %h", g1, e);
            end
         end
      end
      if (load2 && !lp2) begin
         n_cmp++;
         if (q2.size() == 0) begin
            n_err++;
            $display("FAIL dut2_load: got unexpected Load expected none");
         end else begin
            e = q2.pop_front();
            if (g2 !== e) begin
               n_err++;
               $display("FAIL dut2_frame: got %h expected %h", g2, e);
            end
         end
      end
      lp1 <= load1;
      lp2 <= load2;
   end

   task automatic push(input logic [143:0] f);
      q1.push_back(f);
      q2.push_back(f);
   endtask

   // Called and returns at a negedge; checks Count after every transfer (and idle cycle if toggling).
   task automatic send_byte(input logic [7:0] d, input logic l, input logic [4:0] expc, input bit tog);
      int t = 0;
      ain = d; last = l; valid = 1'b1;
      while (!rdy1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         n_cmp++; n_err++;
         $display("FAIL ready_wait: got Ain_ready=0 for 100 cycles expected 1");
      end
      @(negedge clk);
      valid = 1'b0; last = 1'b0;
      chk("count_after_xfer", cnt1, expc);
      if (tog) begin
         @(negedge clk);
         chk("count_idle", cnt1, expc);
      end
   endtask

   task automatic send_frame(input logic [143:0] f, input int first, input int n, input int last_idx,
                             input bit tog);
      int mc = first;
      for (int i = first; i < first + n; i++) begin
         logic l = (i == last_idx);
         if (l || mc == 17) mc = 0; else mc = mc + 1;
         send_byte(f[(i % 18)*8 +: 8], l, 5'(mc), tog);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int nl1, nb1, nr1, nl2, nr2;
      for (int i = 0; i < 18; i++) begin
         f1[i*8 +: 8] = (i == 0) ? 8'h24 : (i < 9) ? 8'h20 : 8'h28;
         f2[i*8 +: 8] = (i < 9) ? 8'h01 : 8'h02;
         f3[i*8 +: 8] = 8'h40 + 8'(i);
         f5[i*8 +: 8] = 8'h80 + 8'(i);
      end

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_count", cnt1, 0);
      chk("rst_load", load1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_ferr", ferr1, 0);
      chk("rst_a00", o1[0], 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", rdy1, 1);

      // Frame 1 with valid held high, then timing of Load/Busy/ready for both instances
      push(f1);
      send_frame(f1, 0, 18, 17, 1'b0);
      chk("load_rise", load1, 1);
      nl1 = 0; nb1 = 0; nr1 = 0; nl2 = 0; nr2 = 0;
      for (int k = 0; k < 10; k++) begin
         nl1 += int'(load1); nb1 += int'(busy1); nr1 += int'(!rdy1);
         nl2 += int'(load2); nr2 += int'(!rdy2);
         if (k == 2) chk("dut2_ready_k2", rdy2, 0);
         if (k == 3) chk("dut2_ready_k3", rdy2, 1);
         @(negedge clk);
      end
      chk("dut1_load_cycles", nl1, 1);
      chk("dut1_busy_cycles", nb1, 5);
      chk("dut1_notready_cycles", nr1, 5);
      chk("dut2_load_cycles", nl2, 3);
      chk("dut2_notready_cycles", nr2, 3);

      // Frame 2 with valid toggling; outputs hold until the final byte
      push(f2);
      send_frame(f2, 0, 17, -1, 1'b1);
      chk("hold_a00", o1[0], 8'h24);
      chk("hold_b22", o1[17], 8'h28);
      send_frame(f2, 17, 1, 17, 1'b1);
      repeat (6) @(negedge clk);

      // Ain_last on byte 10
      send_frame(f3, 0, 10, 9, 1'b0);
      chk("early_last_ferr", ferr1, 1);
      chk("early_last_load", load1, 0);
      @(negedge clk);
      chk("early_last_ferr_pulse", ferr1, 0);
      chk("early_last_a00", o1[0], 8'h01);
      chk("early_last_b22", o1[17], 8'h02);
      push(f3);
      send_frame(f3, 0, 18, 17, 1'b0);
      repeat (6) @(negedge clk);

      // 18 bytes without Ain_last, then 19 bytes without Ain_last
      send_frame(f5, 0, 18, -1, 1'b0);
      chk("no_last_ferr", ferr1, 1);
      @(negedge clk);
      chk("no_last_ferr_pulse", ferr1, 0);
      send_frame(f5, 0, 19, -1, 1'b0);
      chk("nineteen_load", load1, 0);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clear_idle_count", cnt1, 0);

      // Clear alongside byte 5 drops it
      send_frame(f5, 0, 4, -1, 1'b0);
      ain = 8'hEE; valid = 1'b1; clear = 1'b1;
      @(negedge clk);
      valid = 1'b0; clear = 1'b0;
      chk("clear_drop_count", cnt1, 0);

      // Reset during LOAD
      push(f5);
      send_frame(f5, 0, 18, 17, 1'b0);
      chk("pre_rst_load", load1, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_load", load1, 0);
      chk("midrst_busy", busy1, 0);
      chk("midrst_a00", o1[0], 0);
      chk("midrst_b22", o1[17], 0);
      chk("midrst_load2", load2, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", rdy1, 1);

      // First scenario once more: both instances reload frame 1
      push(f1);
      send_frame(f1, 0, 18, 17, 1'b0);
      repeat (8) @(negedge clk);

      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
